// File: rtl/pkt_rr_arbiter_if.sv
// Bus bundle between the packet arbiter, its input FIFOs and the downstream output FIFO.
// The master modport is the arbiter's view; slave is the FIFO/environment view.
interface pkt_rr_arbiter_if #(
  parameter int NPORT = 4,
  parameter int DW    = 34
);
  logic [NPORT-1:0]    empty;
  logic [NPORT*DW-1:0] idata;
  logic [NPORT-1:0]    rd_en;
  logic                ordy;
  logic                wr_en;
  logic [DW-1:0]       odata;
  logic [NPORT-1:0]    grant;
  logic                busy;
  logic                err;

  modport master (
    input  empty, idata, ordy,
    output rd_en, wr_en, odata, grant, busy, err
  );

  modport slave (
    output empty, idata, ordy,
    input  rd_en, wr_en, odata, grant, busy, err
  );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: grants one input FIFO for a whole packet and
// streams its flits into the downstream FIFO until the tail (or truncation) passes.
module pkt_rr_arbiter #(
  parameter int NPORT  = 4,
  parameter int DW     = 34,
  parameter int PKTLEN = 8,
  parameter int CW     = 4
) (
  input  logic             clk,
  input  logic             rst_,
  pkt_rr_arbiter_if.master bus
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state, state_nxt;
  logic [NPORT-1:0] grant_q, grant_nxt;
  logic [PW-1:0]    owner_q, owner_nxt;
  logic [PW-1:0]    ptr_q, ptr_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             err_q, err_nxt;

  logic [DW-1:0]    head [NPORT];
  logic [NPORT-1:0] eligible;
  logic [NPORT-1:0] bad_head;

  // Flit type in the top two bits: 01 head, 00 body, 10 tail, 11 single.
  // Bit 0 marks "starts a packet", bit 1 marks "ends a packet".
  for (genvar i = 0; i < NPORT; i++) begin : g_port
    assign head[i]     = bus.idata[i*DW +: DW];
    assign eligible[i] = ~bus.empty[i] &  head[i][DW-2];
    assign bad_head[i] = ~bus.empty[i] & ~head[i][DW-2];
  end

  logic          found;
  logic [PW-1:0] winner;
  logic [PW-1:0] idx_b;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_b  = '0;
    for (int k = 1; k <= NPORT; k++) begin
      idx_b = PW'((int'(ptr_q) + k) % NPORT);
      if (!found && eligible[idx_b]) begin
        found  = 1'b1;
        winner = idx_b;
      end
    end
  end

  logic [DW-1:0] cur;
  logic [1:0]    ctype;
  logic          xfer;
  logic          at_limit;
  logic          pkt_end;
  logic          trunc;
  logic          mid_head;

  always_comb begin
    cur      = head[owner_q];
    ctype    = cur[DW-1:DW-2];
    xfer     = (state == XFER) && !bus.empty[owner_q];
    at_limit = (cnt_q == CW'(PKTLEN - 1));
    pkt_end  = xfer && (ctype[1] || at_limit);
    trunc    = xfer && !ctype[1] && at_limit;
    mid_head = xfer && ctype[0] && (cnt_q != '0);
  end

  logic [NPORT-1:0] rd_en_c;
  logic             wr_en_c;
  logic [DW-1:0]    odata_c;

  // The FIFO pop and downstream push are the same event, so odata is zero whenever no push happens.
  always_comb begin
    rd_en_c = '0;
    wr_en_c = 1'b0;
    odata_c = '0;
    if (xfer) begin
      rd_en_c[owner_q] = 1'b1;
      wr_en_c          = 1'b1;
      odata_c          = cur;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    owner_nxt = owner_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (|bad_head) err_nxt = 1'b1;
        if (bus.ordy && found) begin
          state_nxt         = XFER;
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          owner_nxt         = winner;
          cnt_nxt           = '0;
        end
      end
      XFER: begin
        // A stalled owner simply holds the grant; there is no timeout.
        if (xfer) begin
          if (trunc || mid_head) err_nxt = 1'b1;
          if (pkt_end) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = owner_q;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer resets to the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state   <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= PW'(NPORT - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      owner_q <= owner_nxt;
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.rd_en = rd_en_c;
  assign bus.wr_en = wr_en_c;
  assign bus.odata = odata_c;
  assign bus.grant = grant_q;
  assign bus.busy  = (state == XFER);
  assign bus.err   = err_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: queue-based input FIFO models feed the arbiter
// and each step compares outputs against hand-computed values.
module tb_pkt_rr_arbiter;

  localparam int NPORT  = 4;
  localparam int DW     = 34;
  localparam int PKTLEN = 8;
  localparam int CW     = 4;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0]    fifo [NPORT][$];
  logic [NPORT-1:0] rd_seen;
  logic [3:0]       seq [5];

  pkt_rr_arbiter_if #(.NPORT(NPORT), .DW(DW)) bus ();

  pkt_rr_arbiter #(
    .NPORT(NPORT), .DW(DW), .PKTLEN(PKTLEN), .CW(CW)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int port, input int idx);
    return {t, 16'hC0DE, 8'(port), 8'(idx)};
  endfunction

  task automatic applyStimulus(input int port, input logic [1:0] t, input int idx);
    fifo[port].push_back(mk(t, port, idx));
  endtask

  task automatic refresh();
    for (int i = 0; i < NPORT; i++) begin
      bus.empty[i] = (fifo[i].size() == 0);
      bus.idata[i*DW +: DW] = (fifo[i].size() == 0) ? '0 : fifo[i][0];
    end
    #1;
  endtask

  // Pops follow the rd_en seen just before the edge, like a real FIFO.
  task automatic tick();
    rd_seen = bus.rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < NPORT; i++)
      if (rd_seen[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    refresh();
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    for (int i = 0; i < NPORT; i++) fifo[i].delete();
    refresh();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_ = 1'b0;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    bus.ordy = 1'b0;
    rst_ = 1'b1;
    refresh();
    @(posedge clk);
    #2;
    checkOutput("rst_grant", bus.grant, 0);
    checkOutput("rst_busy",  bus.busy,  0);
    checkOutput("rst_err",   bus.err,   0);
    checkOutput("rst_wr_en", bus.wr_en, 0);
    checkOutput("rst_rd_en", bus.rd_en, 0);
    checkOutput("rst_odata", bus.odata, 0);
    rst_ = 1'b0;
    #1;

    $display("[TB] two 3-flit packets on ports 0 and 2");
    bus.ordy = 1'b1;
    for (int p = 0; p < 3; p += 2) begin
      applyStimulus(p, 2'b01, 0);
      applyStimulus(p, 2'b00, 1);
      applyStimulus(p, 2'b10, 2);
    end
    refresh();
    tick();
    checkOutput("t1_grant0", bus.grant, 4'b0001);
    checkOutput("t1_busy",   bus.busy,  1);
    checkOutput("t1_rd_en",  bus.rd_en, 4'b0001);
    checkOutput("t1_wr0",    bus.wr_en, 1);
    checkOutput("t1_d0",     bus.odata, mk(2'b01, 0, 0));
    tick();
    checkOutput("t1_wr1",    bus.wr_en, 1);
    checkOutput("t1_d1",     bus.odata, mk(2'b00, 0, 1));
    tick();
    checkOutput("t1_wr2",    bus.wr_en, 1);
    checkOutput("t1_d2",     bus.odata, mk(2'b10, 0, 2));
    tick();
    checkOutput("t1_gap_grant", bus.grant, 0);
    checkOutput("t1_gap_busy",  bus.busy,  0);
    checkOutput("t1_gap_wr",    bus.wr_en, 0);
    checkOutput("t1_gap_odata", bus.odata, 0);
    tick();
    checkOutput("t1_grant2", bus.grant, 4'b0100);
    checkOutput("t1_p2_d0",  bus.odata, mk(2'b01, 2, 0));
    tick();
    tick();
    checkOutput("t1_p2_d2",  bus.odata, mk(2'b10, 2, 2));
    tick();
    checkOutput("t1_end_grant", bus.grant, 0);
    checkOutput("t1_err", bus.err, 0);

    $display("[TB] single-flit packets on all ports");
    do_reset();
    for (int p = 0; p < NPORT; p++) begin
      applyStimulus(p, 2'b11, 0);
      applyStimulus(p, 2'b11, 1);
    end
    refresh();
    for (int s = 0; s < 5; s++) begin
      tick();
      checkOutput($sformatf("t2_grant%0d", s), bus.grant, seq[s]);
      checkOutput($sformatf("t2_data%0d", s), bus.odata, mk(2'b11, s % 4, s / 4));
      tick();
      checkOutput($sformatf("t2_idle%0d", s), bus.grant, 0);
      checkOutput($sformatf("t2_busy%0d", s), bus.busy, 0);
    end
    checkOutput("t2_err", bus.err, 0);

    $display("[TB] ordy held low on port 1 request");
    do_reset();
    bus.ordy = 1'b0;
    applyStimulus(1, 2'b01, 0);
    applyStimulus(1, 2'b10, 1);
    refresh();
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("t3_hold_grant%0d", c), bus.grant, 0);
      checkOutput($sformatf("t3_hold_busy%0d", c), bus.busy, 0);
    end
    bus.ordy = 1'b1;
    #1;
    tick();
    checkOutput("t3_grant", bus.grant, 4'b0010);
    checkOutput("t3_d0",    bus.odata, mk(2'b01, 1, 0));
    tick();
    checkOutput("t3_d1",    bus.odata, mk(2'b10, 1, 1));
    tick();
    checkOutput("t3_end",   bus.grant, 0);
    checkOutput("t3_err",   bus.err, 0);

    $display("[TB] port 3 owner runs dry mid-packet");
    do_reset();
    applyStimulus(3, 2'b01, 0);
    applyStimulus(3, 2'b00, 1);
    refresh();
    tick();
    checkOutput("t4_grant", bus.grant, 4'b1000);
    checkOutput("t4_d0",    bus.odata, mk(2'b01, 3, 0));
    tick();
    checkOutput("t4_d1",    bus.odata, mk(2'b00, 3, 1));
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("t4_stall_wr%0d", c), bus.wr_en, 0);
      checkOutput($sformatf("t4_stall_rd%0d", c), bus.rd_en, 0);
      checkOutput($sformatf("t4_stall_grant%0d", c), bus.grant, 4'b1000);
      checkOutput($sformatf("t4_stall_busy%0d", c), bus.busy, 1);
    end
    applyStimulus(3, 2'b00, 2);
    applyStimulus(3, 2'b10, 3);
    refresh();
    checkOutput("t4_resume_wr", bus.wr_en, 1);
    checkOutput("t4_d2", bus.odata, mk(2'b00, 3, 2));
    tick();
    checkOutput("t4_d3", bus.odata, mk(2'b10, 3, 3));
    tick();
    checkOutput("t4_end_grant", bus.grant, 0);
    checkOutput("t4_end_busy",  bus.busy, 0);
    checkOutput("t4_err", bus.err, 0);

    $display("[TB] tail-less packet truncated at PKTLEN");
    do_reset();
    applyStimulus(0, 2'b01, 0);
    for (int f = 1; f < PKTLEN; f++) applyStimulus(0, 2'b00, f);
    refresh();
    tick();
    checkOutput("t5_grant", bus.grant, 4'b0001);
    checkOutput("t5_d0", bus.odata, mk(2'b01, 0, 0));
    for (int f = 1; f < PKTLEN; f++) begin
      tick();
      checkOutput($sformatf("t5_d%0d", f), bus.odata, mk(2'b00, 0, f));
      checkOutput($sformatf("t5_busy%0d", f), bus.busy, 1);
      checkOutput($sformatf("t5_err%0d", f), bus.err, 0);
    end
    tick();
    checkOutput("t5_end_grant", bus.grant, 0);
    checkOutput("t5_end_busy",  bus.busy, 0);
    checkOutput("t5_end_err",   bus.err, 1);

    $display("[TB] bad head on port 2, then reset mid-packet on port 1");
    do_reset();
    applyStimulus(2, 2'b00, 0);
    refresh();
    tick();
    checkOutput("t6_err", bus.err, 1);
    checkOutput("t6_grant_a", bus.grant, 0);
    checkOutput("t6_busy_a", bus.busy, 0);
    tick();
    checkOutput("t6_grant_b", bus.grant, 0);
    checkOutput("t6_rd_b", bus.rd_en, 0);
    applyStimulus(1, 2'b01, 0);
    applyStimulus(1, 2'b00, 1);
    applyStimulus(1, 2'b00, 2);
    applyStimulus(1, 2'b10, 3);
    refresh();
    tick();
    checkOutput("t6_grant1", bus.grant, 4'b0010);
    checkOutput("t6_d0", bus.odata, mk(2'b01, 1, 0));
    tick();
    checkOutput("t6_d1", bus.odata, mk(2'b00, 1, 1));
    rst_ = 1'b1;
    #1;
    checkOutput("t6_rst_grant", bus.grant, 0);
    checkOutput("t6_rst_busy",  bus.busy, 0);
    checkOutput("t6_rst_err",   bus.err, 0);
    checkOutput("t6_rst_wr",    bus.wr_en, 0);
    #1;
    rst_ = 1'b0;
    #1;
    tick();
    checkOutput("t6_reflag_err", bus.err, 1);
    checkOutput("t6_reflag_grant", bus.grant, 0);
    checkOutput("t6_port1_kept", fifo[1].size(), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
